// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, round constants, byte helpers and FSM/state types.
// Byte 0 occupies bits [127:120]; bytes are column-major (byte = 4*col + row).
package aes_pkg;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} enc_fsm_t;

    // Element [0] maps to the most significant byte of a 128-bit vector.
    typedef logic [0:15][7:0] block_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [3:0] bidx(input logic [1:0] col, input logic [1:0] row);
        return {col, row};
    endfunction

    // Round numbers are 1-based; anything outside 1..10 yields a zero constant.
    function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
        return (rnd >= 4'd1 && rnd <= 4'd10) ? RCON[rnd - 4'd1] : 8'h00;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

endpackage

// File: rtl/aes_enc_iter_if.sv
// Request/response bundle of the iterative AES-128 encryptor.
interface aes_enc_iter_if;
    logic         start;
    logic [127:0] pt_in;
    logic [127:0] key_in;
    logic         ready;
    logic         done;
    logic [127:0] ct_out;
    logic [127:0] last_key;

    modport master (output start, pt_in, key_in, input ready, done, ct_out, last_key);
    modport slave  (input start, pt_in, key_in, output ready, done, ct_out, last_key);
endinterface

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_enc_round
    import aes_pkg::*;
(
    input  block_t state,
    input  block_t rkey,
    input  logic   mix,
    output block_t result
);

    block_t sr;
    block_t mc;
    logic [7:0] a0, a1, a2, a3;

    // Row r of output column c takes the substituted byte from column c+r.
    always_comb begin
        sr = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                sr[bidx(2'(c), 2'(r))] = SBOX[state[bidx(2'(c + r), 2'(r))]];
            end
        end
    end

    always_comb begin
        mc = sr;
        a0 = '0;
        a1 = '0;
        a2 = '0;
        a3 = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = sr[bidx(2'(c), 2'd0)];
            a1 = sr[bidx(2'(c), 2'd1)];
            a2 = sr[bidx(2'(c), 2'd2)];
            a3 = sr[bidx(2'(c), 2'd3)];
            mc[bidx(2'(c), 2'd0)] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[bidx(2'(c), 2'd1)] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[bidx(2'(c), 2'd2)] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[bidx(2'(c), 2'd3)] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    end

    assign result = (mix ? mc : sr) ^ rkey;

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion.
// Exports the round-10 key alongside the ciphertext for the decryption path.
module aes_enc_iter
    import aes_pkg::*;
#(
    parameter int unsigned NR = 10
) (
    input logic          clk,
    input logic          rst,
    aes_enc_iter_if.slave bus
);

    enc_fsm_t    fsm, fsm_nx;
    logic [3:0]  rnd;
    block_t      blk, rk, next_rk, round_out;
    logic [127:0] ct, lk;
    logic        done_r;
    logic        load, step, last, mix;
    logic [31:0] t, w4, w5, w6, w7;

    assign t  = sub_word({rk[13], rk[14], rk[15], rk[12]}) ^ {rcon_of(rnd), 24'h000000};
    assign w4 = rk[0:3] ^ t;
    assign w5 = rk[4:7] ^ w4;
    assign w6 = rk[8:11] ^ w5;
    assign w7 = rk[12:15] ^ w6;
    assign next_rk = {w4, w5, w6, w7};

    assign mix = (rnd != 4'(NR));

    aes_enc_round u_round (
        .state  (blk),
        .rkey   (next_rk),
        .mix    (mix),
        .result (round_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fsm <= IDLE;
        else     fsm <= fsm_nx;
    end

    // Out-of-range round values (0 or above NR) drop straight back to IDLE.
    always_comb begin
        fsm_nx = fsm;
        case (fsm)
            IDLE:    if (bus.start) fsm_nx = RUN;
            RUN:     if (rnd >= 4'(NR) || rnd == 4'd0) fsm_nx = IDLE;
            default: fsm_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.ready = (fsm == IDLE);
        load      = (fsm == IDLE) && bus.start;
        step      = (fsm == RUN) && (rnd != 4'd0) && (rnd <= 4'(NR));
        last      = step && (rnd == 4'(NR));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk    <= '0;
            rk     <= '0;
            rnd    <= '0;
            ct     <= '0;
            lk     <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (load) begin
                blk <= bus.pt_in ^ bus.key_in;
                rk  <= bus.key_in;
                rnd <= 4'd1;
            end else if (step) begin
                blk <= round_out;
                rk  <= next_rk;
                rnd <= last ? 4'd0 : rnd + 4'd1;
                if (last) begin
                    ct     <= round_out;
                    lk     <= next_rk;
                    done_r <= 1'b1;
                end
            end else if (fsm == RUN) begin
                rnd <= '0;
            end
        end
    end

    assign bus.done     = done_r;
    assign bus.ct_out   = ct;
    assign bus.last_key = lk;

endmodule

// File: tb/tb_aes_enc_iter.sv
// Self-checking bench for aes_enc_iter: known-answer vectors, busy/back-to-back/reset
// handling and random blocks against a byte-level AES model with a computed S-box.
module tb_aes_enc_iter;

    localparam logic [127:0] C1K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1P  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1LK = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] ABK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ABP  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] ABCT = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] ABLK = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZCT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic clk = 1'b0;
    logic rst = 1'b1;

    aes_enc_iter_if bus ();

    aes_enc_iter #(.NR(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks  = 0;
    int unsigned n_fail    = 0;
    int unsigned done_seen = 0;
    logic [7:0]  sb [256];

    always @(negedge clk) if (bus.done) done_seen++;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) v = {v[6:0], v[7]};
        return v;
    endfunction

    // S-box from first principles: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = '0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [255:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] k [16];
        logic [7:0] w [4];
        logic [7:0] rc, a0, a1, a2, a3;
        logic [127:0] ct, lk;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[127 - 8 * i -: 8];
            s[i] = pt[127 - 8 * i -: 8] ^ k[i];
        end
        for (int rd = 1; rd <= 10; rd++) begin
            w[0] = sb[k[13]] ^ rc;
            w[1] = sb[k[14]];
            w[2] = sb[k[15]];
            w[3] = sb[k[12]];
            for (int i = 0; i < 16; i++) begin
                if (i < 4) k[i] ^= w[i];
                else       k[i] ^= k[i - 4];
            end
            rc = gmul(rc, 8'h02);
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4 * c + r] = sb[s[4 * ((c + r) % 4) + r]];
            if (rd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4 * c]; a1 = t[4 * c + 1]; a2 = t[4 * c + 2]; a3 = t[4 * c + 3];
                    s[4 * c]     = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4 * c + 1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4 * c + 2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4 * c + 3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end else begin
                s = t;
            end
            for (int i = 0; i < 16; i++) s[i] ^= k[i];
        end
        for (int i = 0; i < 16; i++) begin
            ct[127 - 8 * i -: 8] = s[i];
            lk[127 - 8 * i -: 8] = k[i];
        end
        return {ct, lk};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic launch(input logic [127:0] k, input logic [127:0] p);
        check("launch_ready", 128'(bus.ready), 128'd1);
        bus.start  = 1'b1;
        bus.pt_in  = p;
        bus.key_in = k;
    endtask

    // Returns the negedge count (after the accepting edge) at which done is seen, 0 on timeout.
    task automatic wait_done(input int inj, input logic [127:0] k2, input logic [127:0] p2,
                             input bit hold, output int lat);
        lat = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = n;
                break;
            end
            check("ready_busy", 128'(bus.ready), 128'd0);
            if (n == inj) begin
                bus.start  = 1'b1;
                bus.pt_in  = p2;
                bus.key_in = k2;
            end else if (hold) begin
                bus.pt_in = rand128();
            end else begin
                bus.start = 1'b0;
            end
        end
        if (lat == 0) check("done_timeout", 128'd0, 128'd1);
    endtask

    task automatic run_one(input string tag, input logic [127:0] k, input logic [127:0] p,
                           input logic [127:0] exp_ct, input logic [127:0] exp_lk);
        int lat;
        @(negedge clk);
        launch(k, p);
        wait_done(0, '0, '0, 1'b0, lat);
        check({tag, "_lat"}, 128'(lat), 128'd11);
        check({tag, "_ct"}, bus.ct_out, exp_ct);
        check({tag, "_lk"}, bus.last_key, exp_lk);
        check({tag, "_ready_done"}, 128'(bus.ready), 128'd1);
        @(negedge clk);
        check({tag, "_done_width"}, 128'(bus.done), 128'd0);
        check({tag, "_ct_hold"}, bus.ct_out, exp_ct);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete after %0d checks", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] exp_r;
        logic [127:0] k, p;
        int lat;
        int unsigned seen0;

        bus.start  = 1'b0;
        bus.pt_in  = '0;
        bus.key_in = '0;
        build_sbox();

        repeat (2) @(negedge clk);
        check("rst_ready", 128'(bus.ready), 128'd1);
        check("rst_done", 128'(bus.done), 128'd0);
        check("rst_ct", bus.ct_out, '0);
        check("rst_lk", bus.last_key, '0);
        rst = 1'b0;

        run_one("c1", C1K, C1P, C1CT, C1LK);
        run_one("appb", ABK, ABP, ABCT, ABLK);
        exp_r = aes_ref('0, '0);
        run_one("zero", '0, '0, ZCT, exp_r[127:0]);

        // Busy start at cycle 5 is ignored; a start in the done cycle chains the next block.
        @(negedge clk);
        launch(C1K, C1P);
        wait_done(5, ABK, ABP, 1'b0, lat);
        check("busy_lat", 128'(lat), 128'd11);
        check("busy_ct", bus.ct_out, C1CT);
        check("busy_lk", bus.last_key, C1LK);
        launch(ABK, ABP);
        wait_done(0, '0, '0, 1'b0, lat);
        check("b2b_lat", 128'(lat), 128'd11);
        check("b2b_ct", bus.ct_out, ABCT);
        check("b2b_lk", bus.last_key, ABLK);

        // Reset in the middle of a block.
        @(negedge clk);
        launch(C1K, C1P);
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        seen0 = done_seen;
        #2 rst = 1'b1;
        #1;
        check("rstmid_ready", 128'(bus.ready), 128'd1);
        check("rstmid_ct", bus.ct_out, '0);
        check("rstmid_lk", bus.last_key, '0);
        check("rstmid_done", 128'(bus.done), 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (14) @(negedge clk);
        check("rstmid_no_done", 128'(done_seen), 128'(seen0));
        check("rstmid_ct_after", bus.ct_out, '0);
        run_one("c1_after_rst", C1K, C1P, C1CT, C1LK);

        for (int i = 0; i < 5; i++) begin
            k = rand128();
            p = rand128();
            exp_r = aes_ref(k, p);
            run_one("rand", k, p, exp_r[255:128], exp_r[127:0]);
        end

        // Start held high for three blocks; pt wanders while busy and is captured only on acceptance.
        @(negedge clk);
        k = rand128();
        p = rand128();
        launch(k, p);
        for (int b = 0; b < 3; b++) begin
            exp_r = aes_ref(k, p);
            wait_done(0, '0, '0, 1'b1, lat);
            check("hold_lat", 128'(lat), 128'd11);
            check("hold_ct", bus.ct_out, exp_r[255:128]);
            check("hold_lk", bus.last_key, exp_r[127:0]);
            p = rand128();
            bus.pt_in = p;
        end
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("final_idle_ready", 128'(bus.ready), 128'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_enc_iter.md
Name: aes_enc_iter

Overview:
- Iterative AES-128 encryption core. It is the encrypt-direction counterpart of the team's decryption round logic.
- Accepts one 128-bit plaintext and key per start pulse and runs one round per clock with on-the-fly key expansion.
- Returns the ciphertext with a one-cycle done strobe.
- Also exports the final (round-10) round key, which the decryption path needs as its starting key.

Parameters:
- NR, 10, number of rounds. Fixed for AES-128; any other value is unsupported.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only when ready=1.
- pt_in  input  128  plaintext. Byte 0 = [127:120], column-major per FIPS-197.
- key_in  input  128  cipher key, same byte order.
- ready  output  1  core idle; a start is accepted this cycle.
- done  output  1  one-cycle pulse; ct_out and last_key are valid.
- ct_out  output  128  ciphertext; held until the next completion.
- last_key  output  128  round-10 key; held with ct_out.

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE, round counter to 0.
  - state, round-key, ct_out and last_key registers go to 0.
  - done=0, ready=1.
- FSM states: IDLE, RUN.
- IDLE, start=1 at edge E0:
  - state <= pt_in ^ key_in (initial AddRoundKey).
  - rk <= key_in, rnd <= 1, go to RUN.
  - pt_in and key_in are captured; later changes on them are ignored.
- RUN, edges E1..E10, round rnd:
  - next_rk = KeyExpand(rk, Rcon[rnd]).
  - state <= ShiftRows(SubBytes(state)), then MixColumns when rnd<10, then ^ next_rk.
  - rk <= next_rk, rnd <= rnd+1.
- At E10 (rnd=10):
  - ct_out <= final state, last_key <= next_rk.
  - done <= 1 for exactly one cycle; FSM returns to IDLE.
- Latency: done is high in the cycle after E10, i.e. 11 rising edges including the accepting edge.
- ready = (FSM==IDLE). It is high during the done cycle, so a start there is accepted (back-to-back, 11-cycle throughput).
- start while in RUN is ignored: no queuing, no effect on the current block.
- Rcon sequence for rnd 1..10: 01,02,04,08,10,20,40,80,1b,36.
- KeyExpand: w4 = w0 ^ SubWord(RotWord(w3)) ^ {Rcon,00,00,00}; w5 = w1^w4; w6 = w2^w5; w7 = w3^w6.
- rnd is 4 bits. Values 11..15 are unreachable; if reached, the FSM forces IDLE.
- Reset asserted mid-RUN aborts immediately: no done, ct_out=0 after reset.
- Datapath is one round per cycle: 16 S-boxes for state plus 4 for the key schedule, combinational between registers.

Decomposition:
- Shared package aes_pkg: sbox constant array (256x8), rcon array (10x8), xtime function, and byte/column index helpers matching the team's byte order. The decryption blocks use the same package.
- Sub-module aes_enc_round: combinational SubBytes -> ShiftRows -> optional MixColumns (enable input) -> AddRoundKey.
- Key expansion stays inline in aes_enc_iter; it reuses the package S-box.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, start one cycle. Required:
  - ct_out = 69c4e0d86a7b0430d8cdb78070b4c55a.
  - last_key = 13111d7fe3944a17f307a78b4d2b30c5.
  - done high for exactly 1 cycle, 11 edges after acceptance.
- FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734. Required: ct_out = 3925841d02dc09fbdc118597196a0b32 and last_key = d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key and pt -> ct_out = 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Back-to-back and busy handling:
  - Start the C.1 vector, pulse start again at cycle 5 with the App.B vector: ignored, C.1 result unaffected, ready=0 throughout RUN.
  - Then assert start in the done cycle: second result appears exactly 11 cycles later.
- Assert rst at cycle 6 of RUN:
  - Required: done never pulses, ct_out=0, ready=1 immediately.
  - A subsequent C.1 run completes correctly.
- Hold start high continuously for 3 blocks with a changing pt → done pulses every 11 cycles and each ct_out matches its captured pt.
